vga_fb_slave: RTL and testbench

AXI4 slave framebuffer memory: the responder side of the VGA controller's framebuffer read master and of the offset-mapped write path. It holds pixel data in an internal synchronous-read array. It services INCR/FIXED read bursts for scan-out and write bursts from the CPU side. Read and write channels run independently, so scan-out is never blocked by a CPU write burst.

---
 rtl/vga_fb_slave.sv | 216 +++++++++++++++++++++
 tb/tb_vga_fb_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_slave.sv
// AXI4 slave framebuffer: synchronous-read 64-bit word array with independent
// read (scan-out) and write (CPU) channels, one transaction in flight on each.
module vga_fb_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 4096
) (
   input  logic        clock,
   input  logic        resetn,
   output logic        io_slave_awready,
   input  logic        io_slave_awvalid,
   input  logic [31:0] io_slave_awaddr,
   input  logic [3:0]  io_slave_awid,
   input  logic [7:0]  io_slave_awlen,
   input  logic [2:0]  io_slave_awsize,
   input  logic [1:0]  io_slave_awburst,
   output logic        io_slave_wready,
   input  logic        io_slave_wvalid,
   input  logic [63:0] io_slave_wdata,
   input  logic [7:0]  io_slave_wstrb,
   input  logic        io_slave_wlast,
   input  logic        io_slave_bready,
   output logic        io_slave_bvalid,
   output logic [1:0]  io_slave_bresp,
   output logic [3:0]  io_slave_bid,
   output logic        io_slave_arready,
   input  logic        io_slave_arvalid,
   input  logic [31:0] io_slave_araddr,
   input  logic [3:0]  io_slave_arid,
   input  logic [7:0]  io_slave_arlen,
   input  logic [2:0]  io_slave_arsize,
   input  logic [1:0]  io_slave_arburst,
   input  logic        io_slave_rready,
   output logic        io_slave_rvalid,
   output logic [1:0]  io_slave_rresp,
   output logic [63:0] io_slave_rdata,
   output logic        io_slave_rlast,
   output logic [3:0]  io_slave_rid
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [63:0] mem [DEPTH];

   r_state_t    r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic [1:0]  r_burst;
   logic        ar_fire;
   logic        r_fire;
   logic [31:0] r_next_addr;
   logic [31:0] r_load_addr;
   logic [31:0] r_load_off;
   logic        r_load_in;
   logic [IDX_W-1:0] r_load_idx;

   w_state_t    w_state;
   logic [31:0] w_addr;
   logic [7:0]  w_len;
   logic [7:0]  w_beat;
   logic [1:0]  w_burst;
   logic [3:0]  w_id;
   logic        w_err;
   logic        aw_fire;
   logic        w_fire;
   logic [31:0] w_next_addr;
   logic [31:0] w_off;
   logic        w_in;
   logic [IDX_W-1:0] w_idx;
   logic        w_err_next;

   logic        unused_ok;

   assign ar_fire     = io_slave_arvalid && io_slave_arready;
   assign r_fire      = io_slave_rvalid && io_slave_rready;
   assign r_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + 32'd8;
   // The word loaded into rdata is either beat 0 of a new burst or the next beat.
   assign r_load_addr = (r_state == R_IDLE) ? io_slave_araddr : r_next_addr;
   assign r_load_off  = r_load_addr - BASE_ADDR;
   assign r_load_in   = (r_load_off[31:IDX_W+3] == '0);
   assign r_load_idx  = r_load_off[IDX_W+2:3];

   assign aw_fire     = io_slave_awvalid && io_slave_awready;
   assign w_fire      = io_slave_wvalid && io_slave_wready;
   assign w_next_addr = (w_burst == 2'b00) ? w_addr : w_addr + 32'd8;
   assign w_off       = w_addr - BASE_ADDR;
   assign w_in        = (w_off[31:IDX_W+3] == '0);
   assign w_idx       = w_off[IDX_W+2:3];
   assign w_err_next  = w_err || !w_in ||
                        (io_slave_wlast ? (w_beat != w_len) : (w_beat == w_len));

   assign unused_ok = ^{io_slave_awsize, io_slave_arsize, r_load_off[2:0], w_off[2:0]};

   // Byte-masked commit; loads in the same cycle still see the old word.
   always_ff @(posedge clock) begin
      if (resetn && w_fire && w_in) begin
         for (int i = 0; i < 8; i++) begin
            if (io_slave_wstrb[i]) mem[w_idx][8*i +: 8] <= io_slave_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state          <= R_IDLE;
         io_slave_arready <= 1'b0;
         io_slave_rvalid  <= 1'b0;
         io_slave_rresp   <= 2'b00;
         io_slave_rdata   <= '0;
         io_slave_rlast   <= 1'b0;
         io_slave_rid     <= '0;
         r_addr           <= '0;
         r_len            <= '0;
         r_beat           <= '0;
         r_burst          <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               io_slave_arready <= 1'b1;
               if (ar_fire) begin
                  r_state          <= R_DATA;
                  io_slave_arready <= 1'b0;
                  io_slave_rvalid  <= 1'b1;
                  io_slave_rid     <= io_slave_arid;
                  io_slave_rlast   <= (io_slave_arlen == 8'd0);
                  io_slave_rdata   <= r_load_in ? mem[r_load_idx] : '0;
                  io_slave_rresp   <= r_load_in ? RESP_OKAY : RESP_SLVERR;
                  r_addr           <= io_slave_araddr;
                  r_len            <= io_slave_arlen;
                  r_burst          <= io_slave_arburst;
                  r_beat           <= '0;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (io_slave_rlast) begin
                     r_state          <= R_IDLE;
                     io_slave_rvalid  <= 1'b0;
                     io_slave_arready <= 1'b1;
                  end else begin
                     r_beat         <= r_beat + 8'd1;
                     r_addr         <= r_next_addr;
                     io_slave_rlast <= ((r_beat + 8'd1) == r_len);
                     io_slave_rdata <= r_load_in ? mem[r_load_idx] : '0;
                     io_slave_rresp <= r_load_in ? RESP_OKAY : RESP_SLVERR;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // A burst always runs to wlast; length mismatches and out-of-range beats only flag the error.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         w_state          <= W_IDLE;
         io_slave_awready <= 1'b0;
         io_slave_wready  <= 1'b0;
         io_slave_bvalid  <= 1'b0;
         io_slave_bresp   <= 2'b00;
         io_slave_bid     <= '0;
         w_addr           <= '0;
         w_len            <= '0;
         w_beat           <= '0;
         w_burst          <= '0;
         w_id             <= '0;
         w_err            <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               io_slave_awready <= 1'b1;
               if (aw_fire) begin
                  w_state          <= W_DATA;
                  io_slave_awready <= 1'b0;
                  io_slave_wready  <= 1'b1;
                  w_addr           <= io_slave_awaddr;
                  w_len            <= io_slave_awlen;
                  w_burst          <= io_slave_awburst;
                  w_id             <= io_slave_awid;
                  w_err            <= 1'b0;
                  w_beat           <= '0;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_err  <= w_err_next;
                  w_beat <= w_beat + 8'd1;
                  w_addr <= w_next_addr;
                  if (io_slave_wlast) begin
                     w_state         <= W_RESP;
                     io_slave_wready <= 1'b0;
                     io_slave_bvalid <= 1'b1;
                     io_slave_bid    <= w_id;
                     io_slave_bresp  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            W_RESP: begin
               if (io_slave_bready) begin
                  w_state          <= W_IDLE;
                  io_slave_bvalid  <= 1'b0;
                  io_slave_awready <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_fb_slave.sv
// Directed self-checking bench for vga_fb_slave with hand-computed expectations.
module tb_vga_fb_slave;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 256;

   logic        clock;
   logic        resetn;
   logic        io_slave_awready, io_slave_awvalid;
   logic [31:0] io_slave_awaddr;
   logic [3:0]  io_slave_awid;
   logic [7:0]  io_slave_awlen;
   logic [2:0]  io_slave_awsize;
   logic [1:0]  io_slave_awburst;
   logic        io_slave_wready, io_slave_wvalid, io_slave_wlast;
   logic [63:0] io_slave_wdata;
   logic [7:0]  io_slave_wstrb;
   logic        io_slave_bready, io_slave_bvalid;
   logic [1:0]  io_slave_bresp;
   logic [3:0]  io_slave_bid;
   logic        io_slave_arready, io_slave_arvalid;
   logic [31:0] io_slave_araddr;
   logic [3:0]  io_slave_arid;
   logic [7:0]  io_slave_arlen;
   logic [2:0]  io_slave_arsize;
   logic [1:0]  io_slave_arburst;
   logic        io_slave_rready, io_slave_rvalid, io_slave_rlast;
   logic [1:0]  io_slave_rresp;
   logic [63:0] io_slave_rdata;
   logic [3:0]  io_slave_rid;

   int checkCount = 0;
   int failCount  = 0;

   logic [63:0] wData   [0:15];
   logic [7:0]  wStrb   [0:15];
   logic [63:0] expData [0:15];
   logic [1:0]  expResp [0:15];

   vga_fb_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clock(clock), .resetn(resetn),
      .io_slave_awready(io_slave_awready), .io_slave_awvalid(io_slave_awvalid),
      .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid),
      .io_slave_awlen(io_slave_awlen), .io_slave_awsize(io_slave_awsize),
      .io_slave_awburst(io_slave_awburst),
      .io_slave_wready(io_slave_wready), .io_slave_wvalid(io_slave_wvalid),
      .io_slave_wdata(io_slave_wdata), .io_slave_wstrb(io_slave_wstrb),
      .io_slave_wlast(io_slave_wlast),
      .io_slave_bready(io_slave_bready), .io_slave_bvalid(io_slave_bvalid),
      .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
      .io_slave_arready(io_slave_arready), .io_slave_arvalid(io_slave_arvalid),
      .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
      .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
      .io_slave_arburst(io_slave_arburst),
      .io_slave_rready(io_slave_rready), .io_slave_rvalid(io_slave_rvalid),
      .io_slave_rresp(io_slave_rresp), .io_slave_rdata(io_slave_rdata),
      .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] wordAddr(input int idx);
      return BASE + 32'(idx * 8);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // All bus tasks start and end at 1 time unit after a rising edge.
   task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [1:0] burst, input int nBeats, input logic [1:0] expB,
                             input string tag);
      int waitCnt;
      int cycles;
      io_slave_awaddr = addr; io_slave_awlen = len; io_slave_awid = id;
      io_slave_awburst = burst; io_slave_awsize = 3'd3; io_slave_awvalid = 1'b1;
      waitCnt = 0;
      while (!io_slave_awready && waitCnt < 50) begin @(posedge clock); #1; waitCnt++; end
      checkOutput({tag, "_awready"}, io_slave_awready, 1);
      @(posedge clock); #1;
      io_slave_awvalid = 1'b0;
      checkOutput({tag, "_wready_lat"}, io_slave_wready, 1);
      cycles = 0;
      for (int i = 0; i < nBeats; i++) begin
         io_slave_wvalid = 1'b1; io_slave_wdata = wData[i];
         io_slave_wstrb = wStrb[i]; io_slave_wlast = (i == nBeats - 1);
         waitCnt = 0;
         while (!io_slave_wready && waitCnt < 50) begin @(posedge clock); #1; waitCnt++; cycles++; end
         @(posedge clock); #1;
         cycles++;
      end
      io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
      checkOutput({tag, "_wcycles"}, cycles, nBeats);
      checkOutput({tag, "_bvalid_lat"}, io_slave_bvalid, 1);
      waitCnt = 0;
      while (!io_slave_bvalid && waitCnt < 50) begin @(posedge clock); #1; waitCnt++; end
      checkOutput({tag, "_bresp"}, io_slave_bresp, expB);
      checkOutput({tag, "_bid"}, io_slave_bid, id);
      io_slave_bready = 1'b1;
      @(posedge clock); #1;
      io_slave_bready = 1'b0;
      checkOutput({tag, "_awready_after_b"}, io_slave_awready, 1);
   endtask

   task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] burst, input bit toggle, input string tag);
      int waitCnt;
      int beat;
      int cycles;
      io_slave_araddr = addr; io_slave_arlen = len; io_slave_arid = id;
      io_slave_arburst = burst; io_slave_arsize = 3'd3; io_slave_arvalid = 1'b1;
      waitCnt = 0;
      while (!io_slave_arready && waitCnt < 50) begin @(posedge clock); #1; waitCnt++; end
      checkOutput({tag, "_arready"}, io_slave_arready, 1);
      @(posedge clock); #1;
      io_slave_arvalid = 1'b0;
      checkOutput({tag, "_rvalid_lat"}, io_slave_rvalid, 1);
      io_slave_rready = toggle ? 1'b0 : 1'b1;
      beat = 0;
      cycles = 0;
      while (beat <= int'(len) && cycles < 300) begin
         cycles++;
         checkOutput($sformatf("%s_rvalid_b%0d", tag, beat), io_slave_rvalid, 1);
         checkOutput($sformatf("%s_rdata_b%0d", tag, beat), io_slave_rdata, expData[beat]);
         checkOutput($sformatf("%s_rresp_b%0d", tag, beat), io_slave_rresp, expResp[beat]);
         checkOutput($sformatf("%s_rlast_b%0d", tag, beat), io_slave_rlast, (beat == int'(len)));
         checkOutput($sformatf("%s_rid_b%0d", tag, beat), io_slave_rid, id);
         if (io_slave_rvalid && io_slave_rready) beat++;
         @(posedge clock); #1;
         if (toggle) io_slave_rready = !io_slave_rready;
      end
      io_slave_rready = 1'b0;
      if (!toggle) checkOutput({tag, "_rcycles"}, cycles, int'(len) + 1);
      checkOutput({tag, "_rvalid_end"}, io_slave_rvalid, 0);
   endtask

   task automatic applyStimulus();
      logic [63:0] oldWord;
      logic [63:0] newWord;

      // Single write then read
      wData[0] = 64'h1122334455667788; wStrb[0] = 8'hFF;
      writeBurst(BASE + 32'h10, 8'd0, 4'd3, 2'b01, 1, 2'b00, "single_wr");
      expData[0] = 64'h1122334455667788; expResp[0] = 2'b00;
      readBurst(BASE + 32'h10, 8'd0, 4'd5, 2'b01, 1'b0, "single_rd");

      // Strobe merge
      wData[0] = 64'hFFFF_FFFF_FFFF_FFFF; wStrb[0] = 8'hFF;
      writeBurst(wordAddr(30), 8'd0, 4'd1, 2'b01, 1, 2'b00, "strb_wr1");
      wData[0] = 64'h0; wStrb[0] = 8'h0F;
      writeBurst(wordAddr(30), 8'd0, 4'd1, 2'b01, 1, 2'b00, "strb_wr2");
      expData[0] = 64'hFFFF_FFFF_0000_0000; expResp[0] = 2'b00;
      readBurst(wordAddr(30), 8'd0, 4'd2, 2'b01, 1'b0, "strb_rd");

      // 16-beat INCR fill and backpressured read
      for (int i = 0; i < 16; i++) begin
         wData[i] = 64'(i); wStrb[i] = 8'hFF; expData[i] = 64'(i); expResp[i] = 2'b00;
      end
      writeBurst(wordAddr(0), 8'd15, 4'd1, 2'b01, 16, 2'b00, "fill_wr");
      readBurst(wordAddr(0), 8'd15, 4'd7, 2'b01, 1'b1, "incr16_rd");

      // FIXED burst holds its address
      for (int i = 0; i < 3; i++) begin expData[i] = 64'd5; expResp[i] = 2'b00; end
      readBurst(wordAddr(5), 8'd2, 4'd4, 2'b00, 1'b0, "fixed_rd");

      // Out-of-range read and write
      wData[0] = 64'hA5A5_5A5A_0F0F_F0F0; wStrb[0] = 8'hFF;
      writeBurst(wordAddr(DEPTH - 1), 8'd0, 4'd4, 2'b01, 1, 2'b00, "top_wr");
      expData[0] = 64'hA5A5_5A5A_0F0F_F0F0; expResp[0] = 2'b00;
      expData[1] = 64'h0;                   expResp[1] = 2'b10;
      readBurst(wordAddr(DEPTH - 1), 8'd1, 4'd6, 2'b01, 1'b0, "oor_rd");
      wData[0] = 64'hDEAD_BEEF_DEAD_BEEF; wStrb[0] = 8'hFF;
      writeBurst(wordAddr(DEPTH), 8'd0, 4'd9, 2'b01, 1, 2'b10, "oor_wr");
      expData[0] = 64'h0; expResp[0] = 2'b00;
      readBurst(wordAddr(0), 8'd0, 4'd1, 2'b01, 1'b0, "oor_wr_chk");

      // Early wlast: two beats of a four-beat burst
      for (int i = 0; i < 4; i++) begin wData[i] = 64'h20 + 64'(i); wStrb[i] = 8'hFF; end
      writeBurst(wordAddr(20), 8'd3, 4'd1, 2'b01, 4, 2'b00, "pre20_wr");
      wData[0] = 64'hC0; wData[1] = 64'hC1;
      writeBurst(wordAddr(20), 8'd3, 4'd2, 2'b01, 2, 2'b10, "early_last_wr");
      expData[0] = 64'hC0; expData[1] = 64'hC1; expData[2] = 64'h22; expData[3] = 64'h23;
      for (int i = 0; i < 4; i++) expResp[i] = 2'b00;
      readBurst(wordAddr(20), 8'd3, 4'd3, 2'b01, 1'b0, "early_last_rd");

      // Late wlast: extra beat still written
      wData[0] = 64'hE0; wData[1] = 64'hE1;
      writeBurst(wordAddr(24), 8'd0, 4'd5, 2'b01, 2, 2'b10, "late_last_wr");
      expData[0] = 64'hE0; expData[1] = 64'hE1; expResp[0] = 2'b00; expResp[1] = 2'b00;
      readBurst(wordAddr(24), 8'd1, 4'd5, 2'b01, 1'b0, "late_last_rd");

      // Concurrent 8-beat read and write to disjoint words
      for (int i = 0; i < 8; i++) begin
         wData[i] = 64'h4000 + 64'(i); wStrb[i] = 8'hFF;
         expData[i] = 64'(i); expResp[i] = 2'b00;
      end
      fork
         writeBurst(wordAddr(40), 8'd7, 4'd10, 2'b01, 8, 2'b00, "conc_wr");
         readBurst(wordAddr(0), 8'd7, 4'd11, 2'b01, 1'b0, "conc_rd");
      join
      for (int i = 0; i < 8; i++) expData[i] = 64'h4000 + 64'(i);
      readBurst(wordAddr(40), 8'd7, 4'd12, 2'b01, 1'b0, "conc_chk");

      // Read load and write commit to the same word in the same cycle
      oldWord = 64'h0000_0000_0000_0DD0;
      newWord = 64'h0000_0000_0000_0E70;
      wData[0] = oldWord; wStrb[0] = 8'hFF;
      writeBurst(wordAddr(50), 8'd0, 4'd2, 2'b01, 1, 2'b00, "col_pre");
      io_slave_awaddr = wordAddr(50); io_slave_awlen = 8'd0; io_slave_awid = 4'd2;
      io_slave_awburst = 2'b01; io_slave_awvalid = 1'b1;
      @(posedge clock); #1;
      io_slave_awvalid = 1'b0;
      io_slave_araddr = wordAddr(50); io_slave_arlen = 8'd0; io_slave_arid = 4'd8;
      io_slave_arburst = 2'b01; io_slave_arvalid = 1'b1;
      io_slave_wvalid = 1'b1; io_slave_wdata = newWord; io_slave_wstrb = 8'hFF; io_slave_wlast = 1'b1;
      checkOutput("col_arready", io_slave_arready, 1);
      checkOutput("col_wready", io_slave_wready, 1);
      @(posedge clock); #1;
      io_slave_arvalid = 1'b0; io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
      checkOutput("col_rvalid", io_slave_rvalid, 1);
      checkOutput("col_rdata_old", io_slave_rdata, oldWord);
      checkOutput("col_bvalid", io_slave_bvalid, 1);
      checkOutput("col_bresp", io_slave_bresp, 2'b00);
      io_slave_rready = 1'b1; io_slave_bready = 1'b1;
      @(posedge clock); #1;
      io_slave_rready = 1'b0; io_slave_bready = 1'b0;
      expData[0] = newWord; expResp[0] = 2'b00;
      readBurst(wordAddr(50), 8'd0, 4'd9, 2'b01, 1'b0, "col_new");

      // Reset during beat 4 of an 8-beat read
      io_slave_araddr = wordAddr(0); io_slave_arlen = 8'd7; io_slave_arid = 4'd13;
      io_slave_arburst = 2'b01; io_slave_arvalid = 1'b1;
      checkOutput("rst_arready", io_slave_arready, 1);
      @(posedge clock); #1;
      io_slave_arvalid = 1'b0;
      io_slave_rready = 1'b1;
      repeat (4) begin @(posedge clock); #1; end
      checkOutput("rst_beat4_data", io_slave_rdata, 64'd4);
      resetn = 1'b0;
      @(posedge clock); #1;
      io_slave_rready = 1'b0;
      checkOutput("rst_rvalid", io_slave_rvalid, 0);
      checkOutput("rst_rdata", io_slave_rdata, 0);
      checkOutput("rst_arready_low", io_slave_arready, 0);
      resetn = 1'b1;
      @(posedge clock); #1;
      checkOutput("rst_arready_up", io_slave_arready, 1);
      checkOutput("rst_awready_up", io_slave_awready, 1);
      expData[0] = 64'd3; expResp[0] = 2'b00;
      readBurst(wordAddr(3), 8'd0, 4'd1, 2'b01, 1'b0, "rst_mem_kept");
   endtask

   initial begin
      resetn = 1'b0;
      io_slave_awvalid = 1'b0; io_slave_awaddr = '0; io_slave_awid = '0; io_slave_awlen = '0;
      io_slave_awsize = 3'd3; io_slave_awburst = 2'b01;
      io_slave_wvalid = 1'b0; io_slave_wdata = '0; io_slave_wstrb = '0; io_slave_wlast = 1'b0;
      io_slave_bready = 1'b0;
      io_slave_arvalid = 1'b0; io_slave_araddr = '0; io_slave_arid = '0; io_slave_arlen = '0;
      io_slave_arsize = 3'd3; io_slave_arburst = 2'b01;
      io_slave_rready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_awready", io_slave_awready, 0);
      checkOutput("reset_wready", io_slave_wready, 0);
      checkOutput("reset_bvalid", io_slave_bvalid, 0);
      checkOutput("reset_bresp", io_slave_bresp, 0);
      checkOutput("reset_bid", io_slave_bid, 0);
      checkOutput("reset_arready", io_slave_arready, 0);
      checkOutput("reset_rvalid", io_slave_rvalid, 0);
      checkOutput("reset_rresp", io_slave_rresp, 0);
      checkOutput("reset_rdata", io_slave_rdata, 0);
      checkOutput("reset_rlast", io_slave_rlast, 0);
      checkOutput("reset_rid", io_slave_rid, 0);
      resetn = 1'b1;
      @(posedge clock); #1;
      checkOutput("release_awready", io_slave_awready, 1);
      checkOutput("release_arready", io_slave_arready, 1);
      $display("[TB] reset checks done, running directed traffic");
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
